// File: rtl/eprom2716_pkg.sv
// eprom2716_pkg: shared widths and FSM state encoding for the 2716 EPROM controller
package eprom2716_pkg;
  localparam int EP_ADDR_W = 11;
  localparam int EP_DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACC    = 3'd1,
    PG_SETUP  = 3'd2,
    PG_PULSE  = 3'd3,
    PG_HOLD   = 3'd4,
    PG_VERIFY = 3'd5
  } state_t;
endpackage

// File: rtl/eprom_timer.sv
// eprom_timer: loadable down-counter with zero flag; ports clk, rst_n, ld/val (load), zero (count==0)
module eprom_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (ld) cnt <= val;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/eprom2716_ctrl.sv
// eprom2716_ctrl: 2716 EPROM read / program+verify sequencer; client req/we/addr/wdata -> rdata/ack/busy/verr, device pins ep_*
module eprom2716_ctrl
  import eprom2716_pkg::*;
#(
  parameter int ACC_CYCLES   = 3,
  parameter int SETUP_CYCLES = 2,
  parameter int PGM_CYCLES   = 200000,
  parameter int CNT_W        = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [EP_ADDR_W-1:0] addr,
  input  logic [EP_DATA_W-1:0] wdata,
  output logic [EP_DATA_W-1:0] rdata,
  output logic                 ack,
  output logic                 busy,
  output logic                 verr,
  output logic [EP_ADDR_W-1:0] ep_a,
  output logic [EP_DATA_W-1:0] ep_d_out,
  output logic                 ep_d_oe,
  input  logic [EP_DATA_W-1:0] ep_d_in,
  output logic                 ep_cs_n,
  output logic                 ep_oe_n,
  output logic                 ep_vpp
);
  state_t state, nxt;
  logic acc, done, ld, zero, pg;
  logic [CNT_W-1:0] ld_val;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:              nxt = req ? (we ? PG_SETUP : RD_ACC) : IDLE;
      RD_ACC, PG_VERIFY: nxt = zero ? IDLE : state;
      PG_SETUP:          nxt = zero ? PG_PULSE : state;
      PG_PULSE:          nxt = zero ? PG_HOLD : state;
      PG_HOLD:           nxt = zero ? PG_VERIFY : state;
      default:           nxt = IDLE;
    endcase
  end
  assign acc    = state == IDLE && req;
  assign done   = (state == RD_ACC || state == PG_VERIFY) && zero;
  assign ld     = nxt != state;
  assign pg     = nxt == PG_SETUP || nxt == PG_PULSE || nxt == PG_HOLD;
  assign ld_val = (nxt == RD_ACC || nxt == PG_VERIFY) ? CNT_W'(ACC_CYCLES - 1) :
                  nxt == PG_PULSE ? CNT_W'(PGM_CYCLES - 1) : CNT_W'(SETUP_CYCLES - 1);
  eprom_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (ld),
    .val  (ld_val),
    .zero (zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      ep_cs_n  <= 1'b1;
      ep_oe_n  <= 1'b1;
      ep_vpp   <= 1'b0;
      ep_d_oe  <= 1'b0;
      ep_a     <= '0;
      ep_d_out <= '0;
      rdata    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      verr     <= 1'b0;
    end else begin
      state   <= nxt;
      ep_cs_n <= nxt == IDLE || nxt == PG_PULSE;
      ep_oe_n <= !(nxt == RD_ACC || nxt == PG_VERIFY);
      ep_vpp  <= pg;
      ep_d_oe <= pg;
      busy    <= nxt != IDLE;
      ack     <= done;
      if (acc) ep_a <= addr;
      if (acc && we) ep_d_out <= wdata;
      if (done) rdata <= ep_d_in;
      if (done && state == PG_VERIFY) verr <= ep_d_in != ep_d_out;
    end
endmodule

// File: tb/tb_eprom2716_ctrl.sv
// tb_eprom2716_ctrl: directed + random self-checking bench for eprom2716_ctrl against an interval-based op model
module tb_eprom2716_ctrl;
  localparam int A = 3, S = 2, P = 20;
  localparam int LR = A, LP = 2 * S + P + A;
  logic clk = 0, rst_n, req, we, ack, busy, verr, ep_d_oe, ep_cs_n, ep_oe_n, ep_vpp;
  logic [10:0] addr, ep_a;
  logic [7:0] wdata, rdata, ep_d_out, dev;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  eprom2716_ctrl #(.ACC_CYCLES(A), .SETUP_CYCLES(S), .PGM_CYCLES(P), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .verr(verr), .ep_a(ep_a),
    .ep_d_out(ep_d_out), .ep_d_oe(ep_d_oe), .ep_d_in(dev), .ep_cs_n(ep_cs_n),
    .ep_oe_n(ep_oe_n), .ep_vpp(ep_vpp)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: one op occupies LR or LP cycles after its acceptance edge; k counts edges since acceptance
  int k;
  bit m_act, m_we, m_ack, m_verr;
  logic [10:0] m_a;
  logic [7:0] m_wd, m_rd;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_act = 0; m_ack = 0; m_verr = 0; m_a = 0; m_rd = 0; m_wd = 0; m_we = 0; k = 0;
    end else begin
      m_ack = 0;
      if (m_act) begin
        k++;
        if (k == (m_we ? LP : LR)) begin
          m_act = 0; m_ack = 1; m_rd = dev;
          if (m_we) m_verr = dev != m_wd;
        end
      end else if (req) begin
        m_act = 1; k = 0; m_we = we; m_a = addr; m_wd = wdata;
      end
    end
  always @(negedge clk)
    if (rst_n) begin
      bit pg;
      pg = m_act && m_we && k < 2 * S + P;
      chk("cs_n", ep_cs_n, !m_act || (m_we && k >= S && k < S + P));
      chk("oe_n", ep_oe_n, !(m_act && (!m_we || k >= 2 * S + P)));
      chk("vpp", ep_vpp, pg);
      chk("d_oe", ep_d_oe, pg);
      chk("busy", busy, m_act);
      chk("ack", ack, m_ack);
      chk("ep_a", ep_a, m_a);
      chk("rdata", rdata, m_rd);
      chk("verr", verr, m_verr);
      if (pg) chk("d_out", ep_d_out, m_wd);
      chk("contention_doe", ep_d_oe && !ep_oe_n, 0);
      chk("contention_vpp", ep_vpp && !ep_oe_n, 0);
    end
  task automatic run_op(input bit w, input logic [10:0] a, input logic [7:0] wd, input logic [7:0] din,
                        output int lat, output int cslo, output int vpph, output int csh, output int doeh);
    we = w; addr = a; wdata = wd; dev = din; req = 1;
    lat = 0; cslo = 0; vpph = 0; csh = 0; doeh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      req = 0;
      if (ack) break;
      lat++;
      cslo += int'(!ep_cs_n);
      vpph += int'(ep_vpp);
      csh  += int'(ep_cs_n && ep_vpp);
      doeh += int'(ep_d_oe);
    end
    chk("ack_seen", ack, 1);
  endtask
  initial begin
    int lat, cslo, vpph, csh, doeh, acks;
    rst_n = 1; req = 0; we = 0; addr = 0; wdata = 0; dev = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_cs_n", ep_cs_n, 1); chk("rst_oe_n", ep_oe_n, 1); chk("rst_vpp", ep_vpp, 0);
    chk("rst_d_oe", ep_d_oe, 0); chk("rst_ep_a", ep_a, 0); chk("rst_d_out", ep_d_out, 0);
    chk("rst_rdata", rdata, 0); chk("rst_ack", ack, 0); chk("rst_busy", busy, 0); chk("rst_verr", verr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_op(0, 11'h7FF, 8'h00, 8'hA5, lat, cslo, vpph, csh, doeh);
    chk("rd_lat", lat, 3); chk("rd_cs_lo", cslo, 3); chk("rd_vpp", vpph, 0); chk("rd_doe", doeh, 0);
    chk("rd_rdata", rdata, 8'hA5); chk("rd_busy_ack", busy, 0);
    run_op(1, 11'h123, 8'h3C, 8'h3C, lat, cslo, vpph, csh, doeh);
    chk("pg_lat", lat, 27); chk("pg_vpp", vpph, 24); chk("pg_cs_hi", csh, 20); chk("pg_doe", doeh, 24);
    chk("pg_verr", verr, 0); chk("pg_rdata", rdata, 8'h3C);
    run_op(1, 11'h123, 8'h3C, 8'h3D, lat, cslo, vpph, csh, doeh);
    chk("pgf_verr", verr, 1); chk("pgf_rdata", rdata, 8'h3D);
    run_op(0, 11'h7FF, 8'h00, 8'hA5, lat, cslo, vpph, csh, doeh);
    chk("rd_keep_verr", verr, 1); chk("rd2_rdata", rdata, 8'hA5);
    run_op(1, 11'h055, 8'hAA, 8'hAA, lat, cslo, vpph, csh, doeh);
    chk("pg_clear_verr", verr, 0);
    repeat (2) @(negedge clk);
    we = 0; addr = 11'h010; dev = 8'h5A; req = 1;
    @(negedge clk); req = 0;
    @(negedge clk); req = 1; we = 1; addr = 11'h3FF; wdata = 8'h11;
    @(negedge clk); req = 0;
    for (int i = 0; i < 20 && !ack; i++) @(negedge clk);
    chk("busy_ack", ack, 1); chk("busy_rdata", rdata, 8'h5A); chk("busy_ep_a", ep_a, 11'h010);
    chk("busy_no_pg", ep_vpp, 0);
    we = 0; addr = 11'h200; dev = 8'h77; req = 1;
    @(negedge clk); req = 0;
    chk("b2b_cs_n", ep_cs_n, 0); chk("b2b_ep_a", ep_a, 11'h200);
    for (int i = 0; i < 20 && !ack; i++) @(negedge clk);
    chk("b2b_rdata", rdata, 8'h77);
    we = 1; addr = 11'h444; wdata = 8'h99; dev = 8'h99; req = 1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk); req = 0;
      if (j == S + 9) begin
        chk("pre_rst_cs_n", ep_cs_n, 1); chk("pre_rst_vpp", ep_vpp, 1);
        rst_n = 0;
        #1;
        chk("mid_cs_n", ep_cs_n, 1); chk("mid_oe_n", ep_oe_n, 1); chk("mid_vpp", ep_vpp, 0);
        chk("mid_d_oe", ep_d_oe, 0); chk("mid_busy", busy, 0); chk("mid_ack", ack, 0);
        break;
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    acks = 0;
    repeat (40) @(negedge clk) acks += int'(ack);
    chk("no_ack_after_rst", acks, 0);
    for (int n = 0; n < 200; n++) begin
      logic [7:0] wd, din;
      bit w;
      w = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      din = ($urandom_range(0, 3) == 0) ? wd ^ 8'($urandom_range(1, 255)) : wd;
      run_op(w, 11'($urandom), wd, din, lat, cslo, vpph, csh, doeh);
      chk("rnd_lat", lat, w ? LP : LR);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eprom2716_ctrl.md
Name: eprom2716_ctrl

Overview:
- Host-side controller that drives a 2716 EPROM pin interface: address, data, cs_n, oe_n, vpp.
- Runs timed read cycles and program-plus-verify cycles on behalf of a simple request/ack client.
- Sits between the NASCOM simulation bus/test harness and the eprom2716 device model.
- Owns all 2716 timing: access time, program setup/hold, and the program pulse.

Parameters:
- ACC_CYCLES, 3, clocks from cs_n/oe_n low to read-data sample (>=1)
- SETUP_CYCLES, 2, clocks of address/data/vpp setup before the PGM pulse, and hold after it (>=1)
- PGM_CYCLES, 200000, clocks cs_n is held high as the program pulse (50 ms at 4 MHz, >=1)
- CNT_W, 18, timer width; must hold max(ACC,SETUP,PGM)-1

Ports:
- clk      in   1   system clock
- rst_n    in   1   asynchronous active-low reset
- req      in   1   single-cycle request pulse; sampled only when busy=0
- we       in   1   with req: 1=program+verify, 0=read
- addr     in   11  with req: EPROM address
- wdata    in   8   with req: byte to program
- rdata    out  8   read byte (read) or verify byte (program); valid from ack onward
- ack      out  1   one-cycle completion pulse
- busy     out  1   high from acceptance until the ack cycle (low in the ack cycle)
- verr     out  1   verify mismatch flag from the last program op
- ep_a     out  11  to device a10..a0
- ep_d_out out  8   program data to device d7..d0
- ep_d_oe  out  1   1 = controller drives the data pins
- ep_d_in  in   8   device data outputs
- ep_cs_n  out  1   device cs_n (CE/PGM)
- ep_oe_n  out  1   device oe_n
- ep_vpp   out  1   1 = program voltage applied

Behaviour:
- Reset (async, immediate, including mid-operation):
  - ep_cs_n=1, ep_oe_n=1, ep_vpp=0, ep_d_oe=0.
  - ep_a=0, ep_d_out=0, rdata=0.
  - ack=0, busy=0, verr=0.
  - State=IDLE. An in-progress program pulse is aborted; no ack is issued.
- Acceptance: at edge E0 with state=IDLE and req=1, latch addr/wdata/we. busy=1 from E0. req while busy is ignored.
- All outputs are registered; a single down-counter (timer) is loaded on each state entry.
- States:
  - IDLE: device deselected (cs_n=1, oe_n=1).
  - RD_ACC, entered at E0 (read):
    - ep_a=addr, cs_n=0, oe_n=0.
    - After ACC_CYCLES clocks, at edge E0+ACC_CYCLES: rdata<=ep_d_in, ack=1, busy=0, cs_n=1, oe_n=1, go to IDLE.
    - Read latency is ACC_CYCLES clocks from acceptance to ack.
  - PG_SETUP, entered at E0 (program):
    - ep_a=addr, ep_d_out=wdata, ep_d_oe=1, ep_vpp=1, cs_n=0, oe_n=1.
    - Hold SETUP_CYCLES clocks.
  - PG_PULSE: cs_n=1 for exactly PGM_CYCLES clocks. oe_n stays 1; a, d and vpp are unchanged.
  - PG_HOLD: cs_n=0 for SETUP_CYCLES clocks. On exit, vpp=0 and ep_d_oe=0 on the same edge.
  - PG_VERIFY: cs_n=0, oe_n=0 for ACC_CYCLES clocks, then:
    - rdata<=ep_d_in;
    - verr<=(ep_d_in!=wdata latched);
    - ack=1, busy=0, cs_n=1, oe_n=1, go to IDLE.
- Program latency: 2*SETUP_CYCLES+PGM_CYCLES+ACC_CYCLES clocks from acceptance to ack.
- Bus contention rules:
  - ep_d_oe and !ep_oe_n are never both 1 in any cycle.
  - ep_vpp is never 1 while ep_oe_n=0.
- verr changes only at a program ack. Reads leave it unchanged.
- ep_a holds its last value in IDLE.
- req in the ack cycle is accepted; back-to-back ops are allowed with no idle gap.
- Timer: loaded with N-1 on entry and decremented. The state advances when timer==0 (so N clocks per state). With value 1, the state lasts exactly one clock.

Decomposition:
- eprom2716_pkg holds:
  - state enum {IDLE, RD_ACC, PG_SETUP, PG_PULSE, PG_HOLD, PG_VERIFY};
  - EP_ADDR_W=11, EP_DATA_W=8.
- One natural sub-module: eprom_timer, a loadable CNT_W down-counter with a zero flag. The FSM stays in eprom2716_ctrl.

Test Plan:
- Read timing:
  - Stimulus: reset, then req we=0 addr=11'h7FF with ep_d_in=8'hA5 (ACC=3).
  - Required: cs_n/oe_n low for exactly 3 clocks; ack 3 clocks after acceptance; rdata=A5; busy low in the ack cycle; ep_d_oe=0 throughout.
- Program OK:
  - Stimulus: SETUP=2, PGM=20; req we=1 addr=11'h123 wdata=8'h3C; ep_d_in returns 3C during verify.
  - Required: vpp=1 for 24 clocks; cs_n high for exactly 20 clocks; ack at 27 clocks; verr=0; rdata=3C.
- Program fail:
  - Stimulus: same op, but ep_d_in returns 3D during verify.
  - Required: verr=1 at ack. A following read leaves verr=1; the next successful program clears it.
- Reset mid-pulse:
  - Stimulus: assert rst_n=0 in clock 10 of PG_PULSE.
  - Required: without waiting for a clock edge, vpp=0, cs_n=1, oe_n=1, d_oe=0, busy=0; no ack.
- Busy/back-to-back:
  - Stimulus: req pulses during busy, then req in the ack cycle of a read.
  - Required: the busy-time reqs are ignored; the ack-cycle req starts the next op with cs_n low on the next clock.
- Contention check:
  - Stimulus: randomised mix of 200 read/program ops.
  - Required: assertion never fires for (ep_d_oe && !ep_oe_n) or (ep_vpp && !ep_oe_n).
